// File: rtl/mem_test_initiator.sv
// Core-side bus initiator running a four-phase write/read-back pattern test
// (P, check P, ~P, check ~P) over a word range, reporting pass/fail status.
module mem_test_initiator #(
  parameter int unsigned           BUS_WIDTH      = 32,
  parameter int unsigned           WORD_SIZE_BY   = 4,
  parameter logic [BUS_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter int unsigned           NUM_WORDS      = 1024,
  parameter logic [BUS_WIDTH-1:0]  SEED           = 32'hA5A5A5A5,
  parameter int unsigned           TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [15:0]          error_count,
  output logic [BUS_WIDTH-1:0] first_error_addr,
  output logic                 core_read_memory,
  output logic                 core_write_memory,
  output logic [BUS_WIDTH-1:0] core_address_memory,
  output logic [BUS_WIDTH-1:0] core_write_data_memory,
  input  logic [BUS_WIDTH-1:0] core_read_data_memory,
  input  logic                 core_memory_response
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE} state_e;
  typedef enum logic [1:0] {PH_W0, PH_R0, PH_W1, PH_R1} phase_e;

  state_e               state_q, state_d;
  phase_e               phase_q, phase_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic [15:0]          err_q, err_d;
  logic [BUS_WIDTH-1:0] first_q, first_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;

  logic                 issue_req;
  phase_e               nxt_phase;
  logic [IDX_W-1:0]     nxt_idx;
  logic [BUS_WIDTH-1:0] req_addr;
  logic [BUS_WIDTH-1:0] exp_rdata;

  function automatic logic [BUS_WIDTH-1:0] pattern(input logic [BUS_WIDTH-1:0] a);
    return a ^ SEED;
  endfunction

  function automatic logic [BUS_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + BUS_WIDTH'(i) * BUS_WIDTH'(WORD_SIZE_BY);
  endfunction

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    first_d   = first_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    issue_req = 1'b0;
    nxt_phase = phase_q;
    nxt_idx   = idx_q;
    exp_rdata = (phase_q == PH_R1) ? ~pattern(addr_q) : pattern(addr_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d     = '0;
          first_d   = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          nxt_phase = PH_W0;
          nxt_idx   = '0;
          issue_req = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (core_memory_response) begin
          if (rd_q && (core_read_data_memory != exp_rdata)) begin
            if (err_q == '0) first_d = addr_q;
            if (err_q != '1) err_d = err_q + 16'd1;
          end
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          if (phase_q == PH_R1 && idx_q == LAST_IDX) begin
            // err_d already holds this final compare, so pass sees it.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0) && !timeout_q;
            state_d = S_DONE;
          end else begin
            state_d = S_GAP;
          end
        end else if (tmo_q == LAST_TMO) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          addr_d    = '0;
          wdata_d   = '0;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP: begin
        if (idx_q == LAST_IDX) begin
          nxt_phase = phase_e'(phase_q + 2'd1);
          nxt_idx   = '0;
        end else begin
          nxt_idx   = idx_q + 1'b1;
        end
        issue_req = 1'b1;
        state_d   = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    req_addr = word_addr(nxt_idx);
    if (issue_req) begin
      phase_d = nxt_phase;
      idx_d   = nxt_idx;
      tmo_d   = '0;
      rd_d    = (nxt_phase == PH_R0) || (nxt_phase == PH_R1);
      wr_d    = (nxt_phase == PH_W0) || (nxt_phase == PH_W1);
      addr_d  = req_addr;
      case (nxt_phase)
        PH_W0:   wdata_d = pattern(req_addr);
        PH_W1:   wdata_d = ~pattern(req_addr);
        default: wdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_W0;
      idx_q     <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      first_q   <= first_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign pass                   = pass_q;
  assign timeout                = timeout_q;
  assign error_count            = err_q;
  assign first_error_addr       = first_q;
  assign core_read_memory       = rd_q;
  assign core_write_memory      = wr_q;
  assign core_address_memory    = addr_q;
  assign core_write_data_memory = wdata_q;

endmodule

// File: tb/tb_mem_test_initiator.sv
// Directed bench: a 4-word instance against a scripted responder (normal,
// stuck bit, silent) and a 1024-word instance against random-latency memory.
module tb_mem_test_initiator;

  logic clk = 1'b0;
  logic reset_n, start, start_b;
  always #5 clk = ~clk;

  logic        busy, done, pass, timeout, rd, wr, resp_s;
  logic [15:0] error_count;
  logic [31:0] first_error_addr, addr, wdata, rdata_s;

  logic        busy_b, done_b, pass_b, timeout_b, rd_b, wr_b, resp_b;
  logic [15:0] error_count_b;
  logic [31:0] first_b, addr_b, wdata_b, rdata_b;

  mem_test_initiator #(.NUM_WORDS(4), .TIMEOUT_CYCLES(15)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .error_count(error_count),
    .first_error_addr(first_error_addr), .core_read_memory(rd),
    .core_write_memory(wr), .core_address_memory(addr),
    .core_write_data_memory(wdata), .core_read_data_memory(rdata_s),
    .core_memory_response(resp_s));

  mem_test_initiator #(.NUM_WORDS(1024)) u_big (
    .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .timeout(timeout_b), .error_count(error_count_b),
    .first_error_addr(first_b), .core_read_memory(rd_b),
    .core_write_memory(wr_b), .core_address_memory(addr_b),
    .core_write_data_memory(wdata_b), .core_read_data_memory(rdata_b),
    .core_memory_response(resp_b));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Small responder: mode 0 normal, 1 bit0 stuck-at-1 at 0x8, 2 silent.
  int          mode = 0;
  int          cnt_s;
  int          log_n;
  logic [31:0] mem_s [4];
  logic        prev_req, prev_wr;
  logic [31:0] prev_addr, prev_wdata;
  logic [31:0] log_addr [32];
  logic        log_wr [32];
  logic [31:0] log_wdata [32];
  logic [15:0] err_at_w1;

  initial begin
    resp_s = 1'b0; rdata_s = '0; cnt_s = 0; log_n = 0;
    prev_req = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_s && prev_req) begin
        if (log_n < 32) begin
          log_addr[log_n] = prev_addr; log_wr[log_n] = prev_wr; log_wdata[log_n] = prev_wdata;
        end
        log_n++;
        if (log_n == 9) err_at_w1 = error_count;
        if (prev_wr) mem_s[prev_addr[3:2]] = prev_wdata;
      end
      if ((rd || wr) && mode != 2) begin
        if (cnt_s == 1) begin
          resp_s  = 1'b1;
          rdata_s = mem_s[addr[3:2]] | ((mode == 1 && addr == 32'h8) ? 32'h1 : 32'h0);
        end else begin
          resp_s = 1'b0;
        end
        cnt_s++;
      end else begin
        resp_s = 1'b0; cnt_s = 0;
      end
      prev_req = rd || wr; prev_wr = wr; prev_addr = addr; prev_wdata = wdata;
    end
  end

  // Big responder: correct memory, random 0-7 cycle latency per request.
  int          cnt_b, lat_b, accepts_b;
  logic [31:0] mem_b [1024];
  logic        prev_req_b, prev_wr_b;
  logic [31:0] prev_addr_b, prev_wdata_b;

  initial begin
    resp_b = 1'b0; rdata_b = '0; cnt_b = 0; lat_b = 0; accepts_b = 0;
    prev_req_b = 1'b0; prev_wr_b = 1'b0; prev_addr_b = '0; prev_wdata_b = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_b && prev_req_b) begin
        accepts_b++;
        if (prev_wr_b) mem_b[prev_addr_b[11:2]] = prev_wdata_b;
      end
      if (rd_b || wr_b) begin
        if (cnt_b == 0) lat_b = $urandom_range(0, 7);
        if (cnt_b == lat_b) begin
          resp_b = 1'b1; rdata_b = mem_b[addr_b[11:2]];
        end else begin
          resp_b = 1'b0;
        end
        cnt_b++;
      end else begin
        resp_b = 1'b0; cnt_b = 0;
      end
      prev_req_b = rd_b || wr_b; prev_wr_b = wr_b; prev_addr_b = addr_b; prev_wdata_b = wdata_b;
    end
  end

  // Starts at a negedge; edge 1 samples start. Returns edges until done seen.
  task automatic run_small(input int mode_i, input bit poke, output int edges, output int req_cycles);
    mode = mode_i; log_n = 0; err_at_w1 = 16'hDEAD;
    @(negedge clk);
    start = 1'b1; edges = 0; req_cycles = 0;
    do begin
      @(posedge clk); edges++; #1;
      if (rd || wr) req_cycles++;
      start = poke && edges >= 4 && edges <= 6;
    end while (!done && edges < 400);
    start = 1'b0;
  endtask

  task automatic check_log(input string tag);
    logic [31:0] pat [4];
    int ph, w;
    logic [31:0] exp_data;
    pat[0] = 32'hA5A5A5A5; pat[1] = 32'hA5A5A5A1; pat[2] = 32'hA5A5A5AD; pat[3] = 32'hA5A5A5A9;
    check({tag, "_count"}, 64'(log_n), 64'd16);
    for (int j = 0; j < 16; j++) begin
      ph = j / 4; w = j % 4;
      exp_data = (ph == 0) ? pat[w] : (ph == 2) ? ~pat[w] : 32'h0;
      check($sformatf("%s_addr%0d", tag, j), 64'(log_addr[j]), 64'(4 * w));
      check($sformatf("%s_wr%0d", tag, j), 64'(log_wr[j]), 64'(ph % 2 == 0));
      check($sformatf("%s_data%0d", tag, j), 64'(log_wdata[j]), 64'(exp_data));
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_flags"}, 64'({busy, done, pass, timeout, rd, wr}), 64'd0);
    check({tag, "_err"}, 64'(error_count), 64'd0);
    check({tag, "_first"}, 64'(first_error_addr), 64'd0);
    check({tag, "_addr"}, 64'(addr), 64'd0);
    check({tag, "_wdata"}, 64'(wdata), 64'd0);
  endtask

  int edges, reqc, wait_n;

  initial begin
    reset_n = 1'b0; start = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("rst");
    @(negedge clk); reset_n = 1'b1;

    // Normal run: 48 edges, exact access sequence, clean result
    run_small(0, 1'b0, edges, reqc);
    check("norm_edges", 64'(edges), 64'd48);
    check("norm_status", 64'({busy, done, pass, timeout}), 64'b0110);
    check("norm_err", 64'(error_count), 64'd0);
    check("norm_first", 64'(first_error_addr), 64'd0);
    check_log("norm");

    // Start pulsed while busy must not disturb anything
    run_small(0, 1'b1, edges, reqc);
    check("poke_edges", 64'(edges), 64'd48);
    check("poke_status", 64'({busy, done, pass, timeout}), 64'b0110);
    check_log("poke");

    // Stuck bit at 0x8: R0 clean, one R1 mismatch
    run_small(1, 1'b0, edges, reqc);
    check("stuck_r0_err", 64'(err_at_w1), 64'd0);
    check("stuck_err", 64'(error_count), 64'd1);
    check("stuck_first", 64'(first_error_addr), 64'h8);
    check("stuck_status", 64'({busy, done, pass, timeout}), 64'b0100);

    // Start in DONE clears results on the next cycle
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("restart_err", 64'(error_count), 64'd0);
    check("restart_done_busy", 64'({done, busy}), 64'b01);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    // Silent responder: request held 15 cycles then aborts
    run_small(2, 1'b0, edges, reqc);
    check("tmo_req_cycles", 64'(reqc), 64'd15);
    check("tmo_edges", 64'(edges), 64'd16);
    check("tmo_status", 64'({busy, done, pass, timeout}), 64'b0101);
    check("tmo_req_low", 64'({rd, wr}), 64'd0);

    // Reset during R0, then a full clean rerun
    mode = 0; log_n = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_n = 0;
    while (log_n < 6 && wait_n < 200) begin @(posedge clk); #1; wait_n++; end
    check("mid_reach_r0", 64'(log_n >= 6), 64'd1);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("mid_rst");
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_stay_idle", 64'({busy, rd, wr, done}), 64'd0);
    run_small(0, 1'b0, edges, reqc);
    check("rerun_edges", 64'(edges), 64'd48);
    check("rerun_status", 64'({busy, done, pass, timeout}), 64'b0110);

    // 1024 words with random latency
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    wait_n = 0;
    while (!done_b && wait_n < 60000) begin @(posedge clk); #1; wait_n++; end
    check("big_done", 64'(done_b), 64'd1);
    check("big_pass", 64'({pass_b, timeout_b}), 64'b10);
    check("big_err", 64'(error_count_b), 64'd0);
    check("big_accepts", 64'(accepts_b), 64'd4096);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
